// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//
// Shares the single off-chip SRAM between the audio recorder (write side) and
// the player (read side). Only one access is in flight at a time. When both
// sides request in the same IDLE cycle, the side that was not served last wins,
// so continuous dual traffic alternates W,R,W,R... This block owns every SRAM
// control pin, and all of its outputs come straight from flops.
//
// Access timeline for a request sampled in IDLE during cycle t:
//   t+1 .. t+ACC_CYC   strobe (WE_N or OE_N) low
//   t+ACC_CYC+1        DONE: strobes high, matching ack pulses
//   t+ACC_CYC+2        back in IDLE
//
// Ports
//   i_clk, i_rst                 clock; asynchronous active-high reset
//   i_wr_req/i_wr_addr/i_wr_data write request; hold until o_wr_ack
//   o_wr_ack                     one-cycle pulse when a write completes
//   i_rd_req/i_rd_addr           read request; hold until o_rd_ack
//   o_rd_data, o_rd_ack          read data (held until the next read ack)
//   o_sram_addr                  SRAM address
//   o_sram_we_n, o_sram_oe_n     SRAM strobes, active-low
//   o_sram_dq, o_dq_oe           write data and DQ drive enable
//   i_sram_dq                    sampled SRAM DQ
//   o_busy                       high whenever the FSM is not in IDLE
//   o_state                      debug: 0 IDLE, 1 WRITE, 2 READ, 3 DONE
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_ack,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_busy,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The counter holds the remaining strobe cycles minus one, so an access
    // ends on the cycle it reads zero.
    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

    state_t              state_q,   state_d;
    logic                last_wr_q, last_wr_d;   // 1: last grant went to the writer
    logic [3:0]          cnt_q,     cnt_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                we_n_q,    we_n_d;
    logic                oe_n_q,    oe_n_d;
    logic                dq_oe_q,   dq_oe_d;
    logic                wr_ack_q,  wr_ack_d;
    logic                rd_ack_q,  rd_ack_d;
    logic                busy_q,    busy_d;

    logic                grant_wr_s;

    // Writer wins if it is alone, or if both request and the reader went last.
    always_comb begin
        grant_wr_s = i_wr_req & (~i_rd_req | ~last_wr_q);
    end

    // Next-state and next-output logic; pin values are computed for the state
    // being entered so that every output can be a plain flop.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        we_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        dq_oe_d   = 1'b0;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_wr_s) begin
                    state_d   = ST_WRITE;
                    last_wr_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    addr_d    = i_wr_addr;
                    wdata_d   = i_wr_data;
                    we_n_d    = 1'b0;
                    dq_oe_d   = 1'b1;
                end else if (i_rd_req) begin
                    state_d   = ST_READ;
                    last_wr_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    addr_d    = i_rd_addr;
                    oe_n_d    = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // DQ keeps driving into DONE to cover data hold after WE_N rises.
                dq_oe_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d  = ST_DONE;
                    wr_ack_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    we_n_d = 1'b0;
                end
            end
            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_DONE;
                    rd_data_d = i_sram_dq;
                    rd_ack_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    oe_n_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access at once with no ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            dq_oe_q   <= dq_oe_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign o_wr_ack    = wr_ack_q;
    assign o_rd_ack    = rd_ack_q;
    assign o_rd_data   = rd_data_q;
    assign o_sram_addr = addr_q;
    assign o_sram_we_n = we_n_q;
    assign o_sram_oe_n = oe_n_q;
    assign o_sram_dq   = wdata_q;
    assign o_dq_oe     = dq_oe_q;
    assign o_busy      = busy_q;
    assign o_state     = state_q;

endmodule
